reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of write requesters (fixed at 4 for this revision).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the shared register width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester write request, level-sensitive.
REQ-006 wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  NREQ  one-hot grant, registered.
REQ-008 busy  output  1  high whenever the FSM is not IDLE.
REQ-009 q  output  WIDTH  shared register contents.
REQ-010 qbar  output  WIDTH  bitwise complement of q, always.
REQ-011 owner  output  2  index of the last requester whose write completed.
REQ-012 wr_count  output  8  completed-write counter.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and COOLDOWN.
REQ-014 In IDLE with req==0, the FSM SHALL stay in IDLE, gnt==0 and busy==0.
REQ-015 In IDLE with any req bit set at a rising edge, the FSM SHALL move to GRANT and set gnt to the one-hot winner at that edge.
REQ-016 The winner SHALL be chosen round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last winner.
REQ-017 gnt SHALL stay high for exactly one cycle (the GRANT state).
REQ-018 At the edge leaving GRANT, the block SHALL write q <= winner's wdata slice and qbar <= ~that slice.
REQ-019 At the same edge, ptr and owner SHALL take the winner index, wr_count SHALL increment, and the FSM SHALL move to COOLDOWN.
REQ-020 The write SHALL use wdata sampled at the GRANT-exit edge; deassertion of the winner's req during GRANT SHALL NOT cancel the write.
REQ-021 COOLDOWN SHALL last one cycle with gnt==0, then return to IDLE unconditionally.
REQ-022 Latency: req seen at edge N gives gnt high after edge N and q updated after edge N+1; the next grant is no earlier than edge N+3.
REQ-023 Maximum throughput SHALL be one write per 3 cycles.
REQ-024 Requests arriving in GRANT or COOLDOWN SHALL NOT be granted until the next IDLE evaluation; no request is lost while it is held.
REQ-025 A requester holding req continuously SHALL be granted again only after every other active requester has been served once.
REQ-026 wr_count SHALL wrap from 255 to 0.
REQ-027 q and qbar SHALL change only at the GRANT-exit edge or on reset.

Reset
REQ-028 While rst is high, regardless of clk, the outputs SHALL be forced to: state=IDLE, gnt=0, busy=0, q=0, qbar=all ones, owner=3, ptr=3, wr_count=0.
REQ-029 Reset values SHALL make requester 0 the first winner after reset.
REQ-030 Reset asserted during GRANT SHALL abort the write: q stays 0 and wr_count stays 0.
REQ-031 The first arbitration after reset SHALL occur at the first rising edge with rst low.

Verification
REQ-032 Reset check: assert rst mid-cycle -> gnt=0, q=0x00, qbar=0xFF, wr_count=0 immediately, without waiting for a clock edge.
REQ-033 Single requester: req=0001, wdata[7:0]=0xA5 -> gnt=0001 for one cycle, then q=0xA5, qbar=0x5A, owner=0, wr_count=1, busy low 2 cycles after the grant.
REQ-034 All requesters: req=1111 held -> grants in order 0,1,2,3,0 spaced 3 cycles apart; q follows each requester's data.
REQ-035 Fairness: req2 held, req1 raised after req2's first grant -> next grant goes to req1, then req2.
REQ-036 Late drop and wrap: winner drops req during GRANT -> write still completes; 256 writes -> wr_count returns to 0.
REQ-037 Abort: rst pulsed during GRANT -> no write, q=0x00; after release, requester 0 wins first.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of four requesters a write into a shared register.
// Each grant costs three cycles: IDLE evaluation, GRANT, then COOLDOWN.
module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qbar,
  output logic [1:0]              owner,
  output logic [7:0]              wr_count
);

  typedef enum logic [1:0] {IDLE, GRANT, COOLDOWN} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       pick;
  logic             found;
  logic [WIDTH-1:0] slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign slice[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // Search starts just after the last winner, so the last winner is checked last.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      busy     <= 1'b0;
      q        <= '0;
      qbar     <= '1;
      owner    <= 2'd3;
      ptr      <= 2'd3;
      win      <= 2'd0;
      wr_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= NREQ'(1) << pick;
            busy  <= 1'b1;
            win   <= pick;
          end
        end
        GRANT: begin
          // Data is taken at this edge, so a req drop during GRANT does not cancel it.
          q        <= slice[win];
          qbar     <= ~slice[win];
          ptr      <= win;
          owner    <= win;
          wr_count <= wr_count + 8'd1;
          gnt      <= '0;
          state    <= COOLDOWN;
        end
        COOLDOWN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized self-checking bench for reg_write_arbiter against a transaction-level model.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  q, qbar;
  logic [1:0]  owner;
  logic [7:0]  wr_count;

  int checks = 0;
  int errors = 0;

  // Model: cycles since grant (0 = free to arbitrate), last winner, register state.
  int       m_since;
  int       m_win;
  int       m_ptr;
  int       m_owner;
  logic [7:0] m_q;
  int       m_cnt;
  logic [3:0] m_gnt;

  reg_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt), .busy(busy),
    .q(q), .qbar(qbar), .owner(owner), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_since = 0; m_win = 0; m_ptr = 3; m_owner = 3; m_q = 8'h00; m_cnt = 0; m_gnt = 4'b0;
  endtask

  // Advance one rising edge, applying the transaction rules to the inputs seen there.
  task automatic tick();
    logic [3:0]  r;
    logic [31:0] d;
    @(posedge clk);
    r = req;
    d = wdata;
    if (m_since == 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_since == 0 && r[(m_ptr + k) % 4]) begin
          m_win   = (m_ptr + k) % 4;
          m_since = 1;
        end
      end
      m_gnt = (m_since == 1) ? 4'(1 << m_win) : 4'b0;
    end else if (m_since == 1) begin
      m_q     = d[m_win*8 +: 8];
      m_ptr   = m_win;
      m_owner = m_win;
      m_cnt   = (m_cnt + 1) % 256;
      m_gnt   = 4'b0;
      m_since = 2;
    end else begin
      m_since = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    req = 4'b0001; wdata = 32'h0000_003C;
    for (int i = 0; i < 4; i++) tick();
    req = 4'b0000;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || q !== 8'h00 || qbar !== 8'hFF || wr_count !== 8'd0 || busy !== 1'b0 || owner !== 2'd3) begin
      errors++;
      $display("FAIL reset: gnt=%b q=%h qbar=%h cnt=%0d busy=%b owner=%0d, want 0 00 ff 0 0 3", gnt, q, qbar, wr_count, busy, owner);
    end
    #2;
    rst = 1'b0;
    model_reset();
    $display("test_reset: async reset values observed");
  endtask

  task automatic test_single();
    req = 4'b0001; wdata = {24'($urandom), 8'hA5};
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL single_gnt: gnt=%b busy=%b want 0001 1", gnt, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0 || q !== 8'hA5 || qbar !== 8'h5A || owner !== 2'd0 || wr_count !== 8'd1) begin
      errors++; $display("FAIL single_write: gnt=%b q=%h qbar=%h owner=%0d cnt=%0d want 0000 a5 5a 0 1", gnt, q, qbar, owner, wr_count);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy: busy=%b want 0", busy);
    end
    $display("test_single: q=%h owner=%0d cnt=%0d", q, owner, wr_count);
  endtask

  task automatic test_all();
    int order[$];
    int times[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111; wdata = $urandom;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (gnt !== 4'b0) begin
        order.push_back($clog2(gnt));
        times.push_back(c);
      end
      checks++;
      if ({gnt, busy, q, qbar, owner, wr_count} !== {m_gnt, m_since != 0, m_q, ~m_q, 2'(m_owner), 8'(m_cnt)}) begin
        errors++;
        $display("FAIL all_model c%0d: gnt=%b q=%h owner=%0d cnt=%0d want %b %h %0d %0d", c, gnt, q, owner, wr_count, m_gnt, m_q, m_owner, m_cnt);
      end
    end
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL all_count: grants=%0d want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i] || (i > 0 && times[i] - times[i-1] != 3)) begin
          errors++; $display("FAIL all_order[%0d]: winner=%0d gap=%0d want %0d gap 3", i, order[i], (i > 0) ? times[i] - times[i-1] : 3, exp_order[i]);
        end
      end
    end
    req = 4'b0; tick(); tick(); tick();
    $display("test_all: %0d grants observed", order.size());
  endtask

  task automatic test_fairness();
    int seen[$];
    int exp_seq[3] = '{2, 1, 2};
    do_reset();
    req = 4'b0100; wdata = $urandom;
    for (int c = 0; c < 40 && seen.size() < 3; c++) begin
      tick();
      if (gnt !== 4'b0) begin
        seen.push_back($clog2(gnt));
        req = 4'b0110;
      end
      checks++;
      if ({gnt, q, owner, wr_count} !== {m_gnt, m_q, 2'(m_owner), 8'(m_cnt)}) begin
        errors++; $display("FAIL fair_model c%0d: gnt=%b q=%h want %b %h", c, gnt, q, m_gnt, m_q);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= seen.size() || seen[i] != exp_seq[i]) begin
        errors++; $display("FAIL fair_seq[%0d]: winner=%0d want %0d", i, (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
      end
    end
    req = 4'b0; tick(); tick(); tick();
    $display("test_fairness: %0d grants in sequence", seen.size());
  endtask

  task automatic test_late_drop_wrap();
    int c;
    do_reset();
    req = 4'b0001; wdata = 32'h0000_0011;
    tick();
    req = 4'b0000; wdata = 32'h0000_00C3;
    tick();
    checks++;
    if (q !== 8'hC3 || wr_count !== 8'd1) begin
      errors++; $display("FAIL late_drop: q=%h cnt=%0d want c3 1", q, wr_count);
    end
    c = 0;
    while (m_cnt != 0 && c < 2000) begin
      req = 4'($urandom_range(1, 15)); wdata = $urandom;
      tick();
      c++;
      checks++;
      if ({gnt, busy, q, qbar, owner, wr_count} !== {m_gnt, m_since != 0, m_q, ~m_q, 2'(m_owner), 8'(m_cnt)}) begin
        errors++; $display("FAIL wrap_model c%0d: gnt=%b q=%h cnt=%0d want %b %h %0d", c, gnt, q, wr_count, m_gnt, m_q, m_cnt);
      end
    end
    checks++;
    if (wr_count !== 8'd0 || c >= 2000) begin
      errors++; $display("FAIL wrap: cnt=%0d cycles=%0d want 0 within budget", wr_count, c);
    end
    req = 4'b0; tick(); tick(); tick();
    $display("test_late_drop_wrap: counter wrapped after %0d cycles", c);
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0001; wdata = 32'h0000_0077;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || q !== 8'h00 || wr_count !== 8'd0) begin
      errors++; $display("FAIL abort_hold: gnt=%b q=%h cnt=%0d want 0000 00 0", gnt, q, wr_count);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001 || q !== 8'h00 || wr_count !== 8'd0) begin
      errors++; $display("FAIL abort_first: gnt=%b q=%h cnt=%0d want 0001 00 0", gnt, q, wr_count);
    end
    req = 4'b0; tick(); tick(); tick();
    $display("test_abort: first winner gnt=%b", m_gnt);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
      wdata = $urandom;
      tick();
      checks++;
      if ({gnt, busy, q, qbar, owner, wr_count} !== {m_gnt, m_since != 0, m_q, ~m_q, 2'(m_owner), 8'(m_cnt)}) begin
        errors++;
        $display("FAIL random c%0d: gnt=%b busy=%b q=%h owner=%0d cnt=%0d want %b %b %h %0d %0d", c, gnt, busy, q, owner, wr_count, m_gnt, m_since != 0, m_q, m_owner, m_cnt);
      end
    end
    $display("test_random: final cnt=%0d owner=%0d", wr_count, owner);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; wdata = 32'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    test_reset();
    test_single();
    test_all();
    test_fairness();
    test_late_drop_wrap();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
